// File: rtl/ctr_slice_reg_if.sv
// Control and status bundle for one cascadable counter slice.
// The dn direction input exists only when CTR_SLICE_DOWN_EN is defined.
interface ctr_slice_reg_if #(
  parameter int WIDTH = 4
);
  logic             clr_n;
  logic             ld;
  logic [WIDTH-1:0] din;
  logic             en_p;
  logic             en_t;
`ifdef CTR_SLICE_DOWN_EN
  logic             dn;
`endif
  logic [WIDTH-1:0] q;
  logic             rco;
  logic             tc_pls;
  logic             ld_err;

  modport master (
    output clr_n, ld, din, en_p, en_t,
`ifdef CTR_SLICE_DOWN_EN
    output dn,
`endif
    input  q, rco, tc_pls, ld_err
  );

  modport slave (
    input  clr_n, ld, din, en_p, en_t,
`ifdef CTR_SLICE_DOWN_EN
    input  dn,
`endif
    output q, rco, tc_pls, ld_err
  );
endinterface

// File: rtl/ctr_slice_reg.sv
// Cascadable modulo-(MAXV+1) counter slice: clear/load/count, combinational rco, one-cycle wrap pulse.
// Latency 1 cycle for q/tc_pls/ld_err; no backpressure. Define CTR_SLICE_DOWN_EN to add the dn input.
module ctr_slice_reg #(
  parameter int WIDTH = 4,
  parameter int MAXV  = (1 << WIDTH) - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  ctr_slice_reg_if.slave bus
);
  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAXV);

  logic [WIDTH-1:0] r_q;
  logic             r_tc_pls;
  logic             r_ld_err;

  logic             w_dn;
  logic [WIDTH-1:0] w_term;
  logic             w_at_term;
  logic             w_cnt;
  logic [WIDTH-1:0] w_nxt;
  logic             w_ld_ovf;

`ifdef CTR_SLICE_DOWN_EN
  assign w_dn = bus.dn;
`else
  assign w_dn = 1'b0;
`endif

  // Terminal tracks the current direction so rco and the wrap pulse agree with the next step.
  assign w_term    = w_dn ? '0 : LP_MAX;
  assign w_at_term = (r_q == w_term);
  assign w_cnt     = bus.en_p & bus.en_t & ~bus.ld & bus.clr_n;
  assign w_ld_ovf  = (bus.din > LP_MAX);

  always_comb begin
    w_nxt = r_q;
    if (w_dn) begin
      w_nxt = (r_q == '0) ? LP_MAX : r_q - WIDTH'(1);
    end else begin
      w_nxt = (r_q == LP_MAX) ? '0 : r_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q      <= '0;
      r_tc_pls <= 1'b0;
      r_ld_err <= 1'b0;
    end else if (!bus.clr_n) begin
      r_q      <= '0;
      r_tc_pls <= 1'b0;
    end else if (bus.ld) begin
      // Out-of-range loads saturate so q never leaves 0..MAXV.
      r_q      <= w_ld_ovf ? LP_MAX : bus.din;
      r_tc_pls <= 1'b0;
      if (w_ld_ovf) r_ld_err <= 1'b1;
    end else if (w_cnt) begin
      r_q      <= w_nxt;
      r_tc_pls <= w_at_term;
    end else begin
      r_tc_pls <= 1'b0;
    end
  end

  assign bus.q      = r_q;
  assign bus.tc_pls = r_tc_pls;
  assign bus.ld_err = r_ld_err;
  assign bus.rco    = bus.en_t & w_at_term;
endmodule

// File: tb/tb_ctr_slice_reg.sv
// Directed bench: a two-slice 8-bit cascade (MAXV=15) plus a standalone MAXV=9 slice.
module tb_ctr_slice_reg;
  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  ctr_slice_reg_if #(.WIDTH(4)) if_lo ();
  ctr_slice_reg_if #(.WIDTH(4)) if_hi ();
  ctr_slice_reg_if #(.WIDTH(4)) if_n9 ();

  ctr_slice_reg #(.WIDTH(4), .MAXV(15)) u_lo (.clk(clk), .rst_n(rst_n), .bus(if_lo.slave));
  ctr_slice_reg #(.WIDTH(4), .MAXV(15)) u_hi (.clk(clk), .rst_n(rst_n), .bus(if_hi.slave));
  ctr_slice_reg #(.WIDTH(4), .MAXV(9))  u_n9 (.clk(clk), .rst_n(rst_n), .bus(if_n9.slave));

  // Cascade: shared en_p, lower rco feeds upper en_t.
  assign if_hi.en_p = if_lo.en_p;
  assign if_hi.en_t = if_lo.rco;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_lo(input logic [3:0] v);
    if_lo.ld  = 1'b1;
    if_lo.din = v;
    if_lo.en_p = 1'b0;
    tick();
    if_lo.ld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    if_lo.clr_n = 1'b1; if_lo.ld = 1'b0; if_lo.din = '0; if_lo.en_p = 1'b0; if_lo.en_t = 1'b0;
    if_hi.clr_n = 1'b1; if_hi.ld = 1'b0; if_hi.din = '0;
    if_n9.clr_n = 1'b1; if_n9.ld = 1'b0; if_n9.din = '0; if_n9.en_p = 1'b0; if_n9.en_t = 1'b0;
`ifdef CTR_SLICE_DOWN_EN
    if_lo.dn = 1'b0; if_hi.dn = 1'b0; if_n9.dn = 1'b0;
`endif
    tick();
    tick();
    chk("rst_q", if_lo.q, 0);
    chk("rst_tc", if_lo.tc_pls, 0);
    chk("rst_err", if_lo.ld_err, 0);
    chk("rst_rco", if_lo.rco, 0);
    chk("rst_hi_q", if_hi.q, 0);
    chk("rst_n9_q", if_n9.q, 0);

    // Full up-count sweep with wrap.
    rst_n = 1'b1;
    if_lo.en_p = 1'b1;
    if_lo.en_t = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("sweep_q", if_lo.q, i);
      chk("sweep_rco", if_lo.rco, (i == 15) ? 1 : 0);
      chk("sweep_tc", if_lo.tc_pls, 0);
      tick();
    end
    chk("wrap_q", if_lo.q, 0);
    chk("wrap_tc", if_lo.tc_pls, 1);
    chk("wrap_hi_q", if_hi.q, 1);
    if_lo.en_p = 1'b0;
    tick();
    chk("hold_tc", if_lo.tc_pls, 0);
    chk("hold_q", if_lo.q, 0);

    // en_t low at terminal: hold, no carry; then cascade step.
    load_lo(4'd15);
    chk("ld15_q", if_lo.q, 15);
    if_lo.en_t = 1'b0;
    if_lo.en_p = 1'b1;
    #1;
    chk("ent0_rco", if_lo.rco, 0);
    tick();
    chk("ent0_q", if_lo.q, 15);
    chk("ent0_hi_q", if_hi.q, 1);
    if_lo.en_t = 1'b1;
    #1;
    chk("ent1_rco", if_lo.rco, 1);
    tick();
    chk("casc_lo_q", if_lo.q, 0);
    chk("casc_hi_q", if_hi.q, 2);
    chk("casc_tc", if_lo.tc_pls, 1);
    if_lo.en_p = 1'b0;

    // Clear beats load and count; then load.
    load_lo(4'd7);
    chk("ld7_q", if_lo.q, 7);
    if_lo.ld = 1'b1; if_lo.din = 4'd3; if_lo.en_p = 1'b1; if_lo.en_t = 1'b1; if_lo.clr_n = 1'b0;
    tick();
    chk("clr_q", if_lo.q, 0);
    chk("clr_tc", if_lo.tc_pls, 0);
    if_lo.clr_n = 1'b1;
    tick();
    chk("ld3_q", if_lo.q, 3);
    if_lo.ld = 1'b0;
    if_lo.en_p = 1'b0;

    // Load at terminal with count enabled: load wins, no pulse.
    load_lo(4'd15);
    if_lo.ld = 1'b1; if_lo.din = 4'd5; if_lo.en_p = 1'b1;
    tick();
    chk("ldwin_q", if_lo.q, 5);
    chk("ldwin_tc", if_lo.tc_pls, 0);
    if_lo.ld = 1'b0; if_lo.en_p = 1'b0;

    // MAXV=9 slice: saturating load, sticky error, modulo-10 wrap.
    if_n9.ld = 1'b1; if_n9.din = 4'd12;
    tick();
    chk("n9_sat_q", if_n9.q, 9);
    chk("n9_err", if_n9.ld_err, 1);
    if_n9.ld = 1'b0; if_n9.en_p = 1'b1; if_n9.en_t = 1'b1;
    #1;
    chk("n9_rco", if_n9.rco, 1);
    tick();
    chk("n9_wrap_q", if_n9.q, 0);
    chk("n9_wrap_tc", if_n9.tc_pls, 1);
    chk("n9_err_sticky", if_n9.ld_err, 1);
    if_n9.en_p = 1'b0; if_n9.ld = 1'b1; if_n9.din = 4'd9;
    tick();
    chk("n9_ld9_q", if_n9.q, 9);
    if_n9.ld = 1'b0; if_n9.clr_n = 1'b0;
    tick();
    chk("n9_clr_q", if_n9.q, 0);
    chk("n9_clr_err", if_n9.ld_err, 1);
    if_n9.clr_n = 1'b1;

    // Reset mid-count, overriding a pending overflow load.
    load_lo(4'd10);
    if_lo.en_p = 1'b1; if_lo.en_t = 1'b1;
    tick();
    chk("pre_rst_q", if_lo.q, 11);
    rst_n = 1'b0;
    if_n9.ld = 1'b1; if_n9.din = 4'd12;
    tick();
    chk("rst2_q", if_lo.q, 0);
    chk("rst2_tc", if_lo.tc_pls, 0);
    chk("rst2_n9_err", if_n9.ld_err, 0);
    chk("rst2_n9_q", if_n9.q, 0);
    rst_n = 1'b1;
    if_n9.ld = 1'b0;
    tick();
    chk("resume_q", if_lo.q, 1);
    chk("resume_tc", if_lo.tc_pls, 0);
    if_lo.en_p = 1'b0;

`ifdef CTR_SLICE_DOWN_EN
    // Down count from 0 wraps to MAXV.
    if_lo.clr_n = 1'b0;
    tick();
    if_lo.clr_n = 1'b1;
    if_lo.dn = 1'b1;
    if_lo.en_t = 1'b1;
    #1;
    chk("dn_rco", if_lo.rco, 1);
    if_lo.en_p = 1'b1;
    tick();
    chk("dn_wrap_q", if_lo.q, 15);
    chk("dn_wrap_tc", if_lo.tc_pls, 1);
    chk("dn_rco_off", if_lo.rco, 0);
    tick();
    chk("dn_step_q", if_lo.q, 14);
    if_lo.en_p = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ctr_slice_reg.md
CTR_SLICE_REG -- requirements
Module: ctr_slice_reg

Interface
REQ-001 Parameter WIDTH, default 4: counter slice width in bits; legal range 2..16.
REQ-002 Parameter MAXV, default 2**WIDTH-1: terminal count value; legal range 1..2**WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 clr_n  input  1  synchronous clear, active-low.
REQ-006 ld  input  1  synchronous parallel load, active-high.
REQ-007 din  input  WIDTH  parallel load value.
REQ-008 en_p  input  1  count enable, local.
REQ-009 en_t  input  1  count enable from the upstream slice's carry; also gates rco.
REQ-010 q  output  WIDTH  registered count.
REQ-011 rco  output  1  ripple carry out, combinational, feeds en_t of the next slice.
REQ-012 tc_pls  output  1  registered one-cycle pulse, asserted the cycle after a counting wrap.
REQ-013 ld_err  output  1  registered sticky flag: a load value greater than MAXV was seen.

Function
REQ-014 Update priority per rising edge: rst_n low > clr_n low > ld high > count > hold.
REQ-015 clr_n low: q <= 0; tc_pls <= 0; ld_err unchanged.
REQ-016 ld high with clr_n high: q <= din regardless of en_p and en_t; tc_pls <= 0.
REQ-017 Load with din > MAXV: q <= MAXV (saturated); ld_err <= 1 until reset.
REQ-018 Count condition: en_p & en_t & ~ld & clr_n; otherwise q holds.
REQ-019 Up count: q <= (q == MAXV) ? 0 : q + 1; arithmetic is modulo MAXV+1 and never exceeds MAXV.
REQ-020 rco = en_t & (q == terminal), where terminal = MAXV when counting up; rco is independent of en_p, ld and clr_n.
REQ-021 tc_pls <= 1 exactly when a counting step wraps terminal -> start value; otherwise tc_pls <= 0.
REQ-022 Latency: q reflects a load or count one cycle after the enabling edge; rco follows q and en_t combinationally within the same cycle.
REQ-023 Cascade: N slices chained via rco->en_t with a shared en_p form an N*WIDTH counter; the upper slice increments on the same edge as the lower slice's wrap.
REQ-024 Simultaneous ld and count: load wins; no wrap pulse is produced.
REQ-025 en_t low: q holds and rco = 0, even when q == terminal.

Reset
REQ-026 rst_n low at a rising edge: q <= 0, tc_pls <= 0, ld_err <= 0.
REQ-027 Reset overrides ld, clr_n and the enables in the same cycle.
REQ-028 Reset mid-count: counting resumes from 0 on the first edge after rst_n returns high with enables asserted.
REQ-029 No output is X after the first reset edge.

Configuration
REQ-030 Macro CTR_SLICE_DOWN_EN defined: adds input dn (1 bit, 1 = count down).
- Down count: q <= (q == 0) ? MAXV : q - 1.
- Terminal is 0 when dn = 1 and MAXV when dn = 0; rco and tc_pls use the terminal for the current dn.
- dn may change on any cycle; it takes effect on the next edge.
REQ-031 Macro not defined: no dn port exists; up count only; behaviour as REQ-019/020.

Verification
REQ-032 WIDTH=4, MAXV=15; reset, then en_p=en_t=1 for 16 cycles -> q goes 0..15, then 0; rco=1 only while q=15; tc_pls=1 for one cycle after the wrap to 0.
REQ-033 MAXV=9; ld=1, din=12 -> q=9 and ld_err=1; count 1 cycle -> q=0; ld_err stays 1 until rst_n=0.
REQ-034 q=7, ld=1, din=3, en_p=en_t=1, clr_n=0 in the same cycle -> q=0; next cycle clr_n=1, ld=1 -> q=3.
REQ-035 Two cascaded slices at 8'h0F (lower q=15, upper q=0), one count -> lower q=0, upper q=1 on the same edge; en_t=0 at lower q=15 -> rco=0 and q holds.
REQ-036 rst_n=0 asserted at q=11 while counting -> next edge q=0, tc_pls=0; release -> q=1 after one enabled edge.
REQ-037 With CTR_SLICE_DOWN_EN: q=0, dn=1, count -> q=MAXV and tc_pls=1; rco=1 at q=0 while dn=1 and en_t=1.
